regfile_seq: RTL

- Bus initiator for the 32x32 register file; drives its write port (Addr, Write_Reg, Data) and its read ports (R_Addr_A, R_Addr_B, R_Data_A, R_Data_B).
- FILL loads registers FIRST..LAST from a valid/ready input stream; DUMP reads them back pairwise and streams them out.
- Used for register-file preload and debug readout in the CPU top module.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_seq_outbuf.sv | 38 +++
 rtl/regfile_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared sizes and state encoding for the register-file bus initiator.
package regfile_pkg;

  localparam int RF_AW   = 5;
  localparam int RF_DW   = 32;
  localparam int RF_NREG = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_RD_ISSUE,
    ST_RD_CAP,
    ST_OUT_A,
    ST_OUT_B
  } seq_state_e;

endpackage

// File: rtl/regfile_seq_outbuf.sv
// Holds the captured read pair and presents one word at a time on the
// valid/ready output; data stays put while the consumer stalls.
module regfile_seq_outbuf
  import regfile_pkg::*;
#(
  parameter int DW = RF_DW
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          cap,
  input  logic          show,
  input  logic          sel_b,
  input  logic [DW-1:0] data_a,
  input  logic [DW-1:0] data_b,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          fire
);

  logic [DW-1:0] hold_a;
  logic [DW-1:0] hold_b;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hold_a <= '0;
      hold_b <= '0;
    end else if (cap) begin
      hold_a <= data_a;
      hold_b <= data_b;
    end
  end

  assign out_valid = show;
  assign out_data  = show ? (sel_b ? hold_b : hold_a) : '0;
  assign fire      = show & out_ready;

endmodule

// File: rtl/regfile_seq.sv
// Register-file preload (FILL) and pairwise readout (DUMP) sequencer.
//   state       | meaning
//   IDLE        | waiting for cmd_fill / cmd_dump
//   FILL        | one register write per accepted input beat
//   RD_ISSUE    | read addresses ptr, ptr+1 presented
//   RD_CAP      | read data valid, captured at end of cycle
//   OUT_A       | streaming word for ptr
//   OUT_B       | streaming word for ptr+1
module regfile_seq
  import regfile_pkg::*;
#(
  parameter int DW    = RF_DW,
  parameter int AW    = RF_AW,
  parameter int FIRST = 0,
  parameter int LAST  = RF_NREG - 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          cmd_fill,
  input  logic          cmd_dump,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic [AW-1:0] rf_addr,
  output logic          rf_write_reg,
  output logic [DW-1:0] rf_data,
  output logic [AW-1:0] rf_r_addr_a,
  output logic [AW-1:0] rf_r_addr_b,
  input  logic [DW-1:0] rf_r_data_a,
  input  logic [DW-1:0] rf_r_data_b
);

  // One extra pointer bit so ptr+1 past the top register cannot alias.
  localparam logic [AW:0] P_FIRST = (AW+1)'(FIRST);
  localparam logic [AW:0] P_LAST  = (AW+1)'(LAST);

  seq_state_e  state_q, state_d;
  logic [AW:0] ptr_q, ptr_d, ptr_inc;
  logic        done_d;
  logic        cap, show, sel_b, fire;

  assign ptr_inc = ptr_q + 1'b1;
  assign busy    = (state_q != ST_IDLE);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= P_FIRST;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    done_d       = 1'b0;
    in_ready     = 1'b0;
    rf_write_reg = 1'b0;
    rf_addr      = '0;
    rf_data      = '0;
    rf_r_addr_a  = '0;
    rf_r_addr_b  = '0;
    cap          = 1'b0;
    show         = 1'b0;
    sel_b        = 1'b0;
    out_last     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fill) begin
          state_d = ST_FILL;
          ptr_d   = P_FIRST;
        end else if (cmd_dump) begin
          state_d = ST_RD_ISSUE;
          ptr_d   = P_FIRST;
        end
      end
      ST_FILL: begin
        in_ready     = 1'b1;
        rf_write_reg = in_valid;
        rf_addr      = ptr_q[AW-1:0];
        rf_data      = in_data;
        if (in_valid) begin
          ptr_d = ptr_inc;
          if (ptr_q == P_LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_RD_ISSUE: begin
        rf_r_addr_a = ptr_q[AW-1:0];
        rf_r_addr_b = ptr_inc[AW-1:0];
        state_d     = ST_RD_CAP;
      end
      ST_RD_CAP: begin
        rf_r_addr_a = ptr_q[AW-1:0];
        rf_r_addr_b = ptr_inc[AW-1:0];
        cap         = 1'b1;
        state_d     = ST_OUT_A;
      end
      ST_OUT_A: begin
        show     = 1'b1;
        out_last = (ptr_q == P_LAST);
        if (fire) begin
          if (ptr_q == P_LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_OUT_B;
          end
        end
      end
      ST_OUT_B: begin
        show     = 1'b1;
        sel_b    = 1'b1;
        out_last = (ptr_inc == P_LAST);
        if (fire) begin
          if (ptr_inc == P_LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            ptr_d   = ptr_q + (AW+1)'(2);
            state_d = ST_RD_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort wins over completion; a write beat already on the bus still lands.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end
  end

  regfile_seq_outbuf #(.DW(DW)) u_outbuf (
    .Clk       (Clk),
    .Reset     (Reset),
    .cap       (cap),
    .show      (show),
    .sel_b     (sel_b),
    .data_a    (rf_r_data_a),
    .data_b    (rf_r_data_b),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .fire      (fire)
  );

endmodule
